// File: rtl/suma_pipe.sv
// Two-stage signed add/subtract/accumulate unit with valid/ready on both sides.
// Overflow is judged against the display limit MAX_MAG; define SUMA_SATURATE_EN to clamp instead of zeroing.
module suma_pipe #(
    parameter int WIDTH   = 28,
    parameter int MAX_MAG = 99999999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] n1,
    input  logic [WIDTH-1:0] n2,
    input  logic [1:0]       op,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] d_out,
    output logic             ovrflow
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    localparam logic signed [WIDTH:0]   MAG_POS = (WIDTH+1)'(MAX_MAG);
    localparam logic signed [WIDTH:0]   MAG_NEG = -MAG_POS;
    localparam logic signed [WIDTH-1:0] SAT_POS = WIDTH'(MAX_MAG);
    localparam logic signed [WIDTH-1:0] SAT_NEG = -SAT_POS;
`ifdef SUMA_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic [WIDTH-1:0] s1_n1_reg, s1_n2_reg;
    op_e              s1_op_reg;
    logic             s1_valid_reg;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] d_out_reg;
    logic             ovrflow_reg, valid_out_reg;

    logic                    adv, accept;
    logic signed [WIDTH:0]   a_ext, b_ext, acc_ext, r;
    logic                    n1_big, n2_big, operand_big, ovf;
    logic [WIDTH-1:0]        sat_val, res;

    assign adv       = !valid_out_reg || ready_in;
    assign ready_out = !s1_valid_reg || adv;
    assign accept    = valid_in && ready_out;

    assign valid_out = valid_out_reg;
    assign d_out     = d_out_reg;
    assign ovrflow   = ovrflow_reg;

    // One extra bit keeps r exact for every WIDTH-bit operand pair.
    always_comb begin
        a_ext       = {s1_n1_reg[WIDTH-1], s1_n1_reg};
        b_ext       = {s1_n2_reg[WIDTH-1], s1_n2_reg};
        acc_ext     = {acc_reg[WIDTH-1], acc_reg};
        n1_big      = (a_ext > MAG_POS) || (a_ext < MAG_NEG);
        n2_big      = (b_ext > MAG_POS) || (b_ext < MAG_NEG);
        r           = '0;
        operand_big = 1'b0;
        case (s1_op_reg)
            OP_ADD: begin
                r           = a_ext + b_ext;
                operand_big = n1_big || n2_big;
            end
            OP_SUB: begin
                r           = a_ext - b_ext;
                operand_big = n1_big || n2_big;
            end
            OP_ACC: begin
                r           = acc_ext + a_ext;
                operand_big = n1_big;
            end
            default: begin
                r           = '0;
                operand_big = 1'b0;
            end
        endcase
        ovf = (s1_op_reg != OP_CLR) && (operand_big || (r > MAG_POS) || (r < MAG_NEG));

        sat_val = '0;
        if (SAT_EN)
            sat_val = (!r[WIDTH] && (r != '0)) ? SAT_POS : SAT_NEG;
        res = ovf ? sat_val : r[WIDTH-1:0];

        acc_next = acc_reg;
        if (s1_op_reg == OP_ACC && (!ovf || SAT_EN))
            acc_next = res;
        else if (s1_op_reg == OP_CLR)
            acc_next = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_n1_reg     <= '0;
            s1_n2_reg     <= '0;
            s1_op_reg     <= OP_ADD;
            s1_valid_reg  <= 1'b0;
            acc_reg       <= '0;
            d_out_reg     <= '0;
            ovrflow_reg   <= 1'b0;
            valid_out_reg <= 1'b0;
        end else begin
            if (accept) begin
                s1_n1_reg    <= n1;
                s1_n2_reg    <= n2;
                s1_op_reg    <= op_e'(op);
                s1_valid_reg <= 1'b1;
            end else if (adv) begin
                s1_valid_reg <= 1'b0;
            end

            // acc only moves together with a result entering S2, so a stalled output freezes it.
            if (adv) begin
                valid_out_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    d_out_reg   <= res;
                    ovrflow_reg <= ovf;
                    acc_reg     <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_suma_pipe.sv
// Bench for suma_pipe: directed steps followed by random traffic, all results
// checked against an integer reference model of the add/sub/accumulate rules.
module tb_suma_pipe;

    localparam int     W    = 28;
    localparam longint MAXM = 99999999;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] n1 = '0, n2 = '0;
    logic [1:0]   op = 2'b00;
    logic         valid_in = 1'b0;
    logic         ready_in = 1'b1;
    logic         ready_out, valid_out, ovrflow;
    logic [W-1:0] d_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         o;
    } exp_t;
    exp_t   exp_q[$];
    longint acc_m = 0;

    suma_pipe #(.WIDTH(W), .MAX_MAG(int'(MAXM))) dut (
        .clk(clk), .rst(rst), .n1(n1), .n2(n2), .op(op),
        .valid_in(valid_in), .ready_out(ready_out), .valid_out(valid_out),
        .ready_in(ready_in), .d_out(d_out), .ovrflow(ovrflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint mag(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: exact integer arithmetic, then the display-limit rules.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint x, y, r, dv;
        bit     ovf, sat;
        x = $signed(a);
        y = $signed(b);
        r = 0;
        ovf = 0;
        sat = 0;
`ifdef SUMA_SATURATE_EN
        sat = 1;
`endif
        case (o)
            ADD: begin r = x + y;     ovf = mag(x) > MAXM || mag(y) > MAXM; end
            SUB: begin r = x - y;     ovf = mag(x) > MAXM || mag(y) > MAXM; end
            ACC: begin r = acc_m + x; ovf = mag(x) > MAXM; end
            default: r = 0;
        endcase
        if (o != CLR && mag(r) > MAXM) ovf = 1;
        if (!ovf)     dv = r;
        else if (sat) dv = (r > 0) ? MAXM : -MAXM;
        else          dv = 0;
        if (o == ACC && (!ovf || sat)) acc_m = dv;
        if (o == CLR) acc_m = 0;
        e.d = dv[W-1:0];
        e.o = ovf;
        return e;
    endfunction

    // Scoreboard: every accepted op queues an expectation, every consumed result pops one.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            acc_m = 0;
        end else begin
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid_out", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_d_out", $signed(d_out), $signed(e.d));
                    chk("sb_ovrflow", ovrflow, e.o);
                end
            end
            if (valid_in && ready_out)
                exp_q.push_back(model(op, n1, n2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op and hold it until it transfers; returns 1ns after the transfer edge.
    task automatic send(input logic [1:0] o, input longint a, input longint b);
        op = o;
        n1 = a[W-1:0];
        n2 = b[W-1:0];
        valid_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready_out) begin
                tick();
                valid_in = 1'b0;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        valid_in = 1'b0;
    endtask

    task automatic send_chk(input string tag, input logic [1:0] o, input longint a, input longint b,
                            input longint d, input bit ov);
        send(o, a, b);
        @(negedge clk);
        chk({tag, "_not_yet_valid"}, valid_out, 0);
        tick();
        @(negedge clk);
        chk({tag, "_valid"}, valid_out, 1);
        chk({tag, "_d_out"}, $signed(d_out), d);
        chk({tag, "_ovrflow"}, ovrflow, ov);
        tick();
    endtask

    function automatic longint rval();
        longint v;
        case ($urandom_range(0, 3))
            0: v = $urandom_range(0, 1000);
            1: v = $urandom_range(0, 99999999);
            2: v = MAXM - 20 + $urandom_range(0, 40);
            default: v = $signed(W'($urandom));
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    longint sat_ovf_add, sat_acc;

    initial begin
`ifdef SUMA_SATURATE_EN
        sat_ovf_add = MAXM;
        sat_acc     = MAXM;
`else
        sat_ovf_add = 0;
        sat_acc     = -8;
`endif
        // Reset held for five cycles.
        repeat (5) begin
            @(negedge clk);
            chk("reset_valid_out", valid_out, 0);
            chk("reset_d_out", $signed(d_out), 0);
            chk("reset_ovrflow", ovrflow, 0);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready_out", ready_out, 1);
        chk("post_reset_valid_out", valid_out, 0);
        tick();

        send_chk("add_412_3534", ADD, 412, 3534, 3946, 0);
        @(negedge clk);
        chk("add_single_pulse", valid_out, 0);
        tick();
        send_chk("sub_100_m50", SUB, 100, -50, 150, 0);

        // Overflowing ADD immediately followed by an in-range one.
        send(ADD, 99999900, 120);
        send(ADD, -2556, 120);
        @(negedge clk);
        chk("ovf_add_d_out", $signed(d_out), sat_ovf_add);
        chk("ovf_add_flag", ovrflow, 1);
        tick();
        @(negedge clk);
        chk("after_ovf_d_out", $signed(d_out), -2436);
        chk("after_ovf_flag", ovrflow, 0);
        tick();

        // Back-to-back accumulate chain.
        send(CLR, 0, 0);
        send(ACC, 5, 0);
        send(ACC, 7, 0);
        send(ACC, -20, 0);
        @(negedge clk);
        chk("acc_chain_12", $signed(d_out), 12);
        tick();
        @(negedge clk);
        chk("acc_chain_m8", $signed(d_out), -8);
        tick();
        send(ACC, 100000010, 0);
        send(ACC, 0, 0);
        @(negedge clk);
        chk("acc_ovf_flag", ovrflow, 1);
        tick();
        @(negedge clk);
        chk("acc_after_ovf", $signed(d_out), sat_acc);
        chk("acc_after_ovf_flag", ovrflow, 0);
        tick();

        // Backpressure: two ops fill the pipe, the third must wait.
        ready_in = 1'b0;
        send(ADD, 1, 2);
        send(SUB, 10, 3);
        op = ACC;
        n1 = W'(4);
        n2 = '0;
        valid_in = 1'b1;
        @(negedge clk);
        chk("full_ready_out", ready_out, 0);
        chk("full_d_out", $signed(d_out), 3);
        tick();
        @(negedge clk);
        chk("stall_hold_d_out", $signed(d_out), 3);
        chk("stall_ready_out", ready_out, 0);
        tick();
        ready_in = 1'b1;
        @(negedge clk);
        chk("drain_ready_out", ready_out, 1);
        tick();
        valid_in = 1'b0;
        @(negedge clk);
        chk("drain_second", $signed(d_out), 7);
        tick();
        @(negedge clk);
        chk("drain_third_valid", valid_out, 1);
        tick();

        // Reset while an ACC sits in S1.
        send(ACC, 5, 0);
        send(ACC, 7, 0);
        op = ACC;
        n1 = W'(3);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        rst = 1'b0;
        #1;
        chk("midreset_valid_out", valid_out, 0);
        chk("midreset_d_out", $signed(d_out), 0);
        tick();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_output_after_reset", valid_out, 0);
            tick();
        end
        send_chk("acc_after_reset", ACC, 1, 0, 1, 0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            valid_in = ($urandom_range(0, 2) != 0);
            op       = 2'($urandom_range(0, 3));
            n1       = W'(rval());
            n2       = W'(rval());
            ready_in = ($urandom_range(0, 3) != 0);
            tick();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
